// File: rtl/compare_result_monitor_if.sv
// Flag, strobe and result bundle between the magnitude comparator side and the
// result monitor. The master drives the sampled flags and reads back the filtered relation.
interface compare_result_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             SAMPLE;
  logic             ALTB;
  logic             AEQB;
  logic             AGTB;
  logic             CLR;
  logic             STATE_LT;
  logic             STATE_EQ;
  logic             STATE_GT;
  logic             CHANGE;
  logic [CNT_W-1:0] GT_COUNT;
  logic [CNT_W-1:0] EQ_COUNT;
  logic             ERR;

  modport master (
    output SAMPLE, ALTB, AEQB, AGTB, CLR,
    input  STATE_LT, STATE_EQ, STATE_GT, CHANGE, GT_COUNT, EQ_COUNT, ERR
  );

  modport slave (
    input  SAMPLE, ALTB, AEQB, AGTB, CLR,
    output STATE_LT, STATE_EQ, STATE_GT, CHANGE, GT_COUNT, EQ_COUNT, ERR
  );
endinterface

// File: rtl/compare_result_monitor.sv
// Persistence filter for comparator flags: a relation is accepted after HOLD
// consecutive identical one-hot samples; exposes change pulse, entry counters, sticky error.
module compare_result_monitor #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  compare_result_monitor_if.slave   bus
);

  typedef enum logic [1:0] {S_UNKNOWN, S_LT, S_EQ, S_GT} state_t;
  typedef enum logic [1:0] {C_NONE, C_LT, C_EQ, C_GT} cand_t;

  localparam logic [3:0] HOLD_V = 4'(HOLD);

  state_t           state, state_n;
  cand_t            cand, cand_n, code;
  state_t           code_state;
  logic [3:0]       run, run_n;
  logic             change, change_n;
  logic [CNT_W-1:0] gt_cnt, gt_cnt_n, eq_cnt, eq_cnt_n;
  logic             err, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_UNKNOWN;
      cand   <= C_NONE;
      run    <= '0;
      change <= 1'b0;
      gt_cnt <= '0;
      eq_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      run    <= run_n;
      change <= change_n;
      gt_cnt <= gt_cnt_n;
      eq_cnt <= eq_cnt_n;
      err    <= err_n;
    end
  end

  always_comb begin
    code       = C_NONE;
    code_state = S_UNKNOWN;
    case ({bus.ALTB, bus.AEQB, bus.AGTB})
      3'b100:  begin code = C_LT; code_state = S_LT; end
      3'b010:  begin code = C_EQ; code_state = S_EQ; end
      3'b001:  begin code = C_GT; code_state = S_GT; end
      default: begin code = C_NONE; code_state = S_UNKNOWN; end
    endcase
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    run_n    = run;
    change_n = 1'b0;
    gt_cnt_n = gt_cnt;
    eq_cnt_n = eq_cnt;
    err_n    = err;

    if (bus.SAMPLE) begin
      if (code != C_NONE) begin
        if (code == cand) begin
          run_n = (run >= HOLD_V) ? HOLD_V : run + 4'd1;
        end else begin
          cand_n = code;
          run_n  = 4'd1;
        end
        // Acceptance is judged on the updated run so HOLD=1 accepts on first sample.
        if (run_n == HOLD_V && code_state != state) begin
          state_n  = code_state;
          change_n = 1'b1;
          if (code_state == S_GT && gt_cnt != '1) gt_cnt_n = gt_cnt + 1'b1;
          if (code_state == S_EQ && eq_cnt != '1) eq_cnt_n = eq_cnt + 1'b1;
        end
      end else begin
        err_n  = 1'b1;
        cand_n = C_NONE;
        run_n  = '0;
      end
    end

    if (bus.CLR) begin
      gt_cnt_n = '0;
      eq_cnt_n = '0;
      err_n    = 1'b0;
    end
  end

  assign bus.STATE_LT = (state == S_LT);
  assign bus.STATE_EQ = (state == S_EQ);
  assign bus.STATE_GT = (state == S_GT);
  assign bus.CHANGE   = change;
  assign bus.GT_COUNT = gt_cnt;
  assign bus.EQ_COUNT = eq_cnt;
  assign bus.ERR      = err;

endmodule

// File: tb/tb_compare_result_monitor.sv
// Directed, table-driven bench for compare_result_monitor (HOLD=4/CNT_W=8 instance)
// plus a saturating HOLD=1/CNT_W=2 instance and an asynchronous reset sequence.
module tb_compare_result_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compare_result_monitor_if #(.CNT_W(8)) bus1 ();
  compare_result_monitor_if #(.CNT_W(2)) bus2 ();

  compare_result_monitor #(.HOLD(4), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  compare_result_monitor #(.HOLD(1), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic       s, lt, eq, gt, clr;
    logic [2:0] st;   // {LT,EQ,GT}
    logic       ch;
    logic [7:0] gc, ec;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(logic s, logic l, logic e, logic g, logic c,
                             logic [2:0] st, logic ch, logic [7:0] gc,
                             logic [7:0] ec, logic er);
    vec_t r;
    r.s = s; r.lt = l; r.eq = e; r.gt = g; r.clr = c;
    r.st = st; r.ch = ch; r.gc = gc; r.ec = ec; r.er = er;
    return r;
  endfunction

  function automatic logic [20:0] act1();
    return {bus1.STATE_LT, bus1.STATE_EQ, bus1.STATE_GT, bus1.CHANGE,
            bus1.GT_COUNT, bus1.EQ_COUNT, bus1.ERR};
  endfunction

  task automatic check1(string name, logic [2:0] st, logic ch, logic [7:0] gc,
                        logic [7:0] ec, logic er);
    logic [20:0] exp;
    logic [20:0] got;
    exp = {st, ch, gc, ec, er};
    got = act1();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%b ch=%b gc=%0d ec=%0d err=%b, want st=%b ch=%b gc=%0d ec=%0d err=%b",
               name, got[20:18], got[17], got[16:9], got[8:1], got[0],
               st, ch, gc, ec, er);
    end
  endtask

  task automatic drive1(logic s, logic l, logic e, logic g, logic c);
    bus1.SAMPLE = s; bus1.ALTB = l; bus1.AEQB = e; bus1.AGTB = g; bus1.CLR = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(logic s, logic e, logic g);
    bus2.SAMPLE = s; bus2.ALTB = 1'b0; bus2.AEQB = e; bus2.AGTB = g; bus2.CLR = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus1.SAMPLE = 0; bus1.ALTB = 0; bus1.AEQB = 0; bus1.AGTB = 0; bus1.CLR = 0;
    bus2.SAMPLE = 0; bus2.ALTB = 0; bus2.AEQB = 0; bus2.AGTB = 0; bus2.CLR = 0;

    //                s l e g c   st    ch gc ec er
    // GT x4 from reset
    tbl.push_back(v(1,0,0,1,0, 3'b000,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b000,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b000,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b001,1, 1, 0, 0));
    // LT x3, GT x1, LT x4
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b001,0, 1, 0, 0));
    tbl.push_back(v(1,1,0,0,0, 3'b100,1, 1, 0, 0));
    // EQ samples separated by two-cycle gaps
    tbl.push_back(v(1,0,1,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,1,1,1,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(1,0,1,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(1,0,1,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b100,0, 1, 0, 0));
    tbl.push_back(v(1,0,1,0,0, 3'b010,1, 1, 1, 0));
    tbl.push_back(v(0,0,0,0,0, 3'b010,0, 1, 1, 0));
    // two flags high: sticky error, run cleared
    tbl.push_back(v(1,1,1,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,0,1,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,0,1,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,0,1,0,0, 3'b010,0, 1, 1, 1));
    // LT x3, no-flag sample breaks the run, one more LT must not accept
    tbl.push_back(v(1,1,0,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,1,0,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,1,0,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,0,0,0,0, 3'b010,0, 1, 1, 1));
    tbl.push_back(v(1,1,0,0,0, 3'b010,0, 1, 1, 1));
    // CLR, then CLR colliding with a GT entry and with an error
    tbl.push_back(v(0,0,0,0,1, 3'b010,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b010,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b010,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,0, 3'b010,0, 0, 0, 0));
    tbl.push_back(v(1,0,0,1,1, 3'b001,1, 0, 0, 0));
    tbl.push_back(v(1,1,1,1,1, 3'b001,0, 0, 0, 0));
    tbl.push_back(v(1,1,1,1,0, 3'b001,0, 0, 0, 1));
    tbl.push_back(v(0,0,0,0,0, 3'b001,0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    check1("reset", 3'b000, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2;

    foreach (tbl[i]) begin
      drive1(tbl[i].s, tbl[i].lt, tbl[i].eq, tbl[i].gt, tbl[i].clr);
      check1($sformatf("vec%0d", i), tbl[i].st, tbl[i].ch, tbl[i].gc, tbl[i].ec, tbl[i].er);
    end

    // asynchronous reset after two of four GT samples; needs four fresh ones
    drive1(1, 0, 0, 1, 0);
    drive1(1, 0, 0, 1, 0);
    #3 rst_n = 1'b0;
    #1 check1("async_rst", 3'b000, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      drive1(1, 0, 0, 1, 0);
      check1($sformatf("post_rst_gt%0d", k), 3'b000, 0, 0, 0, 0);
    end
    drive1(1, 0, 0, 1, 0);
    check1("post_rst_accept", 3'b001, 1, 1, 0, 0);
    drive1(0, 0, 0, 0, 0);
    check1("post_rst_idle", 3'b001, 0, 1, 0, 0);

    // HOLD=1, CNT_W=2 instance: alternate EQ/GT, counters saturate at 3
    begin
      int unsigned me, mg;
      logic [6:0] got2, exp2;
      me = 0; mg = 0;
      for (int unsigned k = 0; k < 10; k++) begin
        if (k % 2 == 0) begin
          drive2(1, 1, 0);
          if (me < 3) me++;
          exp2 = {3'b010, 1'b1, 2'(mg), 1'b0};
        end else begin
          drive2(1, 0, 1);
          if (mg < 3) mg++;
          exp2 = {3'b001, 1'b1, 2'(mg), 1'b0};
        end
        got2 = {bus2.STATE_LT, bus2.STATE_EQ, bus2.STATE_GT, bus2.CHANGE,
                bus2.GT_COUNT, bus2.ERR};
        n_vec++;
        if (got2 !== exp2 || bus2.EQ_COUNT !== 2'(me)) begin
          n_bad++;
          $display("FAIL sat%0d: got {st,ch,gc,err}=%b ec=%0d, want %b ec=%0d",
                   k, got2, bus2.EQ_COUNT, exp2, me);
        end
      end
      drive2(0, 0, 0);
      n_vec++;
      if (bus2.CHANGE !== 1'b0 || bus2.GT_COUNT !== 2'd3 || bus2.EQ_COUNT !== 2'd3) begin
        n_bad++;
        $display("FAIL sat_idle: got ch=%b gc=%0d ec=%0d, want ch=0 gc=3 ec=3",
                 bus2.CHANGE, bus2.GT_COUNT, bus2.EQ_COUNT);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
